// File: rtl/sparc_pkg.sv
// sparc_pkg: shared encodings for the SPARC pipeline sequencing controller
package sparc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2, ANNUL = 2'd3} state_t;
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_EX = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB = 2'b11;
  localparam logic [3:0] COND_BA = 4'b1000;
  localparam logic [4:0] G0 = 5'd0;
endpackage

// File: rtl/forward_select.sv
// forward_select: picks one operand's source, youngest producer first; %g0 never forwards
module forward_select
  import sparc_pkg::*;
#(
  parameter int RD_W = 5
) (
  input  logic [RD_W-1:0] rs,
  input  logic [RD_W-1:0] ex_rd,
  input  logic [RD_W-1:0] mem_rd,
  input  logic [RD_W-1:0] wb_rd,
  input  logic            ex_rf_en,
  input  logic            mem_rf_en,
  input  logic            wb_rf_en,
  input  logic            ex_load,
  output logic [1:0]      fwd
);
  logic ex_hit, mem_hit, wb_hit;
  always_comb begin
    ex_hit = ex_rf_en & ~ex_load & (rs == ex_rd) & (ex_rd != RD_W'(G0));
    mem_hit = mem_rf_en & (rs == mem_rd) & (mem_rd != RD_W'(G0));
    wb_hit = wb_rf_en & (rs == wb_rd) & (wb_rd != RD_W'(G0));
    fwd = ex_hit ? FWD_EX : mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
  end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: sequences the 5-stage pipeline enables, stalls, annuls and forwarding
module pipeline_hazard_controller
  import sparc_pkg::*;
#(
  parameter int RD_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [RD_W-1:0]  id_rs1,
  input  logic [RD_W-1:0]  id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_branch,
  input  logic             id_cond_true,
  input  logic             id_annul,
  input  logic             id_branch_always,
  input  logic [RD_W-1:0]  ex_rd,
  input  logic [RD_W-1:0]  mem_rd,
  input  logic [RD_W-1:0]  wb_rd,
  input  logic             ex_rf_en,
  input  logic             mem_rf_en,
  input  logic             wb_rf_en,
  input  logic             ex_load,
  input  logic             ex_cc_en,
  output logic             pc_le,
  output logic             if_id_le,
  output logic             if_id_flush,
  output logic             cu_mux_s,
  output logic             pc_sel,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] annul_cnt
);
  state_t state, next_state;
  logic lu, hz, go, stall, ann;
  logic [1:0] raw_a, raw_b;
  forward_select #(.RD_W(RD_W)) u_fwd_a (
    .rs(id_rs1), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_rf_en(ex_rf_en),
    .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en), .ex_load(ex_load), .fwd(raw_a)
  );
  forward_select #(.RD_W(RD_W)) u_fwd_b (
    .rs(id_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_rf_en(ex_rf_en),
    .mem_rf_en(mem_rf_en), .wb_rf_en(wb_rf_en), .ex_load(ex_load), .fwd(raw_b)
  );
  // STALL and ANNUL both follow the RUN rules, so only IDLE differs
  always_comb begin
    lu = ex_load & ex_rf_en & ex_rd != RD_W'(G0) &
         ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd));
    hz = lu | (id_branch & ex_cc_en);
    stall = state != IDLE & hz;
    go = state != IDLE & ~hz;
    ann = go & id_branch & id_annul & (~id_cond_true | id_branch_always);
    pc_le = go;
    if_id_le = go;
    cu_mux_s = ~go;
    pc_sel = go & id_branch & id_cond_true;
    if_id_flush = state == IDLE | ann;
    fwd_a = go ? raw_a : FWD_RF;
    fwd_b = go ? raw_b : FWD_RF;
    next_state = state == IDLE ? (start ? RUN : IDLE) : stall ? STALL : ann ? ANNUL : RUN;
    state_o = state;
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      stall_cnt <= '0;
      annul_cnt <= '0;
    end else begin
      state <= next_state;
      if (stall && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
      if (ann && ~&annul_cnt) annul_cnt <= annul_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller: directed vectors checked against a behavioural model every cycle
module tb_pipeline_hazard_controller;
  localparam int CW = 4;
  logic clk = 0, clr = 0, start = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0, mem_rd = 0, wb_rd = 0;
  logic id_use_rs1 = 0, id_use_rs2 = 0, id_branch = 0, id_cond_true = 0, id_annul = 0;
  logic id_branch_always = 0, ex_rf_en = 0, mem_rf_en = 0, wb_rf_en = 0, ex_load = 0, ex_cc_en = 0;
  logic pc_le, if_id_le, if_id_flush, cu_mux_s, pc_sel;
  logic [1:0] fwd_a, fwd_b, state_o;
  logic [CW-1:0] stall_cnt, annul_cnt;
  int tests = 0, fails = 0;
  pipeline_hazard_controller #(.RD_W(5), .CNT_W(CW)) dut (
    .clk(clk), .clr(clr), .start(start), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_branch(id_branch),
    .id_cond_true(id_cond_true), .id_annul(id_annul), .id_branch_always(id_branch_always),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_rf_en(ex_rf_en), .mem_rf_en(mem_rf_en),
    .wb_rf_en(wb_rf_en), .ex_load(ex_load), .ex_cc_en(ex_cc_en), .pc_le(pc_le),
    .if_id_le(if_id_le), .if_id_flush(if_id_flush), .cu_mux_s(cu_mux_s), .pc_sel(pc_sel),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state_o(state_o), .stall_cnt(stall_cnt), .annul_cnt(annul_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int fsel(input logic [4:0] rs);
    if (ex_rf_en && !ex_load && rs != 0 && rs == ex_rd) return 1;
    if (mem_rf_en && rs != 0 && rs == mem_rd) return 2;
    if (wb_rf_en && rs != 0 && rs == wb_rd) return 3;
    return 0;
  endfunction
  int ms = 0, m_stall = 0, m_annul = 0;
  bit hz, go, e_ann;
  always @* begin
    hz = (ex_load && ex_rf_en && ex_rd != 0 &&
          ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd))) ||
         (id_branch && ex_cc_en);
    go = ms != 0 && !hz;
    e_ann = go && id_branch && id_annul && (!id_cond_true || id_branch_always);
  end
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      ms <= 0; m_stall <= 0; m_annul <= 0;
    end else if (ms == 0) ms <= start ? 1 : 0;
    else if (hz) begin
      ms <= 2;
      m_stall <= m_stall == (1 << CW) - 1 ? m_stall : m_stall + 1;
    end else if (e_ann) begin
      ms <= 3;
      m_annul <= m_annul == (1 << CW) - 1 ? m_annul : m_annul + 1;
    end else ms <= 1;
  end
  always @(negedge clk) begin
    chk("m_state", int'(state_o), ms);
    chk("m_pc_le", int'(pc_le), int'(go));
    chk("m_if_id_le", int'(if_id_le), int'(go));
    chk("m_cu_mux_s", int'(cu_mux_s), int'(!go));
    chk("m_pc_sel", int'(pc_sel), int'(go && id_branch && id_cond_true));
    chk("m_flush", int'(if_id_flush), int'(ms == 0 || e_ann));
    chk("m_fwd_a", int'(fwd_a), go ? fsel(id_rs1) : 0);
    chk("m_fwd_b", int'(fwd_b), go ? fsel(id_rs2) : 0);
    chk("m_stall_cnt", int'(stall_cnt), m_stall);
    chk("m_annul_cnt", int'(annul_cnt), m_annul);
  end
  task automatic nxt;
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) nxt();
    @(negedge clk);
    chk("rst_state", int'(state_o), 0);
    chk("rst_pc_le", int'(pc_le), 0);
    chk("rst_cu_s", int'(cu_mux_s), 1);
    chk("rst_flush", int'(if_id_flush), 1);
    chk("rst_cnt", int'(stall_cnt) + int'(annul_cnt), 0);
    nxt();
    clr = 1;
    start = 1;
    @(negedge clk);
    chk("idle_state", int'(state_o), 0);
    nxt();
    start = 0;
    @(negedge clk);
    chk("run_state", int'(state_o), 1);
    chk("run_pc_le", int'(pc_le), 1);
    nxt();
    ex_load = 1; ex_rd = 5; ex_rf_en = 1; id_rs1 = 5; id_use_rs1 = 1;
    @(negedge clk);
    chk("lu_pc_le", int'(pc_le), 0);
    chk("lu_if_id_le", int'(if_id_le), 0);
    chk("lu_cu_s", int'(cu_mux_s), 1);
    nxt();
    ex_load = 0; ex_rf_en = 0; ex_rd = 0; mem_rd = 5; mem_rf_en = 1;
    @(negedge clk);
    chk("lu_state", int'(state_o), 2);
    chk("lu_stall_cnt", int'(stall_cnt), 1);
    chk("lu_fwd_a", int'(fwd_a), 2);
    nxt();
    mem_rd = 0; mem_rf_en = 0; ex_load = 1; ex_rf_en = 1; ex_rd = 0; id_rs1 = 0;
    @(negedge clk);
    chk("g0_pc_le", int'(pc_le), 1);
    chk("g0_fwd_a", int'(fwd_a), 0);
    nxt();
    ex_load = 0; ex_rd = 7; mem_rd = 7; wb_rd = 7; mem_rf_en = 1; wb_rf_en = 1;
    id_rs2 = 7; id_use_rs2 = 1; id_use_rs1 = 0;
    @(negedge clk);
    chk("pri_ex", int'(fwd_b), 1);
    nxt();
    ex_rf_en = 0;
    @(negedge clk);
    chk("pri_mem", int'(fwd_b), 2);
    nxt();
    mem_rf_en = 0;
    @(negedge clk);
    chk("pri_wb", int'(fwd_b), 3);
    nxt();
    wb_rf_en = 0; id_rs2 = 0; id_use_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    id_branch = 1; id_cond_true = 1; id_annul = 1; id_branch_always = 1;
    @(negedge clk);
    chk("ba_pc_sel", int'(pc_sel), 1);
    chk("ba_flush", int'(if_id_flush), 1);
    nxt();
    id_cond_true = 0; id_branch_always = 0;
    @(negedge clk);
    chk("ba_state", int'(state_o), 3);
    chk("ba_annul_cnt", int'(annul_cnt), 1);
    chk("bne_nt_pc_sel", int'(pc_sel), 0);
    chk("bne_nt_flush", int'(if_id_flush), 1);
    nxt();
    id_cond_true = 1;
    @(negedge clk);
    chk("bne_t_pc_sel", int'(pc_sel), 1);
    chk("bne_t_flush", int'(if_id_flush), 0);
    chk("bne_annul_cnt", int'(annul_cnt), 2);
    nxt();
    id_annul = 0; ex_cc_en = 1;
    @(negedge clk);
    chk("cc_state_run", int'(state_o), 1);
    chk("cc_pc_sel", int'(pc_sel), 0);
    chk("cc_pc_le", int'(pc_le), 0);
    nxt();
    @(negedge clk);
    chk("cc_state", int'(state_o), 2);
    chk("cc_stall_cnt", int'(stall_cnt), 2);
    repeat (18) nxt();
    @(negedge clk);
    chk("sat_stall_cnt", int'(stall_cnt), 15);
    chk("sat_state", int'(state_o), 2);
    nxt();
    clr = 0;
    #1;
    chk("clr_state", int'(state_o), 0);
    chk("clr_stall_cnt", int'(stall_cnt), 0);
    chk("clr_annul_cnt", int'(annul_cnt), 0);
    id_branch = 0; id_cond_true = 0; ex_cc_en = 0;
    repeat (2) nxt();
    clr = 1;
    repeat (2) nxt();
    @(negedge clk);
    chk("post_idle", int'(state_o), 0);
    nxt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Sequencing controller for the 5-stage SPARC pipeline (IF/ID/EX/MEM/WB) built from PC_Reg/nPC_Reg and the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers. It drives the PC/nPC/IF_ID load enables, the IF_ID flush, the CU-mux NOP select S and the PC source select. It also generates operand-forwarding selects, handles load-use and condition-code stalls and delay-slot annulment, and counts stall cycles. It replaces the free-running LE/S/reset stimulus used in the phase-3 bench.

Parameters:
RD_W, 5, register-specifier width
CNT_W, 16, stall/annul counter width (saturating)

Ports:
clk  in  1  pipeline clock, rising edge
clr  in  1  asynchronous active-low reset
start  in  1  leave IDLE and begin fetching
id_rs1, id_rs2  in  RD_W  source registers of instruction in ID
id_use_rs1, id_use_rs2  in  1  ID instruction reads rs1/rs2 (rs2 unused when I13=1)
id_branch  in  1  ID holds a Bicc
id_cond_true  in  1  Bicc condition evaluated true (from condition handler)
id_annul  in  1  I29 'a' bit of the ID branch
id_branch_always  in  1  cond == BA (4'b1000)
ex_rd, mem_rd, wb_rd  in  RD_W  destination register per stage
ex_rf_en, mem_rf_en, wb_rf_en  in  1  register-file write enable per stage
ex_load  in  1  EX holds a load
ex_cc_en  in  1  EX instruction updates icc
pc_le  out  1  load enable, PC_Reg and nPC_Reg
if_id_le  out  1  load enable, IF_ID
if_id_flush  out  1  synchronous clear of IF_ID (annul)
cu_mux_s  out  1  1 = CU mux emits all-zero (NOP) signals into ID_EX
pc_sel  out  1  0 = nPC+4, 1 = branch target into nPC
fwd_a, fwd_b  out  2  operand source: 00 RF, 01 EX, 10 MEM, 11 WB
state_o  out  2  current state
stall_cnt, annul_cnt  out  CNT_W  saturating event counters

Behaviour:
- Interface: one clock clk; clr asynchronous, active-low. On clr=0: state=IDLE, counters=0.
- States: IDLE=0, RUN=1, STALL=2, ANNUL=3.
- IDLE: pc_le=0, if_id_le=0, cu_mux_s=1, if_id_flush=1, pc_sel=0, fwd=00. start=1 -> RUN on next edge.
- Hazard terms (combinational):
  - match(r,x) = r==x and x!=0 (%g0 is never a hazard or forwarding source).
  - lu = ex_load & ex_rf_en & ((id_use_rs1 & match(id_rs1,ex_rd)) | (id_use_rs2 & match(id_rs2,ex_rd))).
  - cch = id_branch & ex_cc_en.
- Stall (RUN or ANNUL with lu|cch):
  - pc_le=0, if_id_le=0, cu_mux_s=1, pc_sel=0; branch decision suppressed.
  - Next state is STALL; stall_cnt+1.
- STALL: exactly one bubble cycle. Outputs follow the RUN rules using the current hazard terms, so a fresh hazard restalls. A back-to-back load-use never occurs, because the load has moved to MEM.
- RUN, no hazard:
  - pc_le=1, if_id_le=1, cu_mux_s=0.
  - pc_sel = id_branch & id_cond_true.
  - ann = id_branch & id_annul & (~id_cond_true | id_branch_always). If ann: if_id_flush=1 this cycle, so the delay slot is latched as NOP; next state ANNUL; annul_cnt+1. Otherwise next state RUN.
- ANNUL: one cycle; the NOP sits in ID; behaves as RUN. Next state RUN, or ANNUL if another annul occurs.
- Forwarding, per operand, priority EX > MEM > WB:
  - EX hit needs rf_en & match & ~ex_load.
  - MEM and WB hits need rf_en & match.
  - No hit gives 00.
  - During a stall, fwd is don't-care; drive 00.
- Counters saturate at all-ones and never wrap.
- All outputs are combinational from state and inputs; only state and the counters are registered.
- clr asserted mid-stall or mid-annul returns to IDLE immediately; no pending event survives.

Decomposition:
- Shared package (sparc_pkg): state encodings, FWD_RF/EX/MEM/WB constants, COND_BA=4'b1000, G0=5'd0.
- One natural sub-module, forward_select: purely combinational, instantiated twice (fwd_a, fwd_b).

Test Plan:
- Reset/start: clr=0 for 2 cycles, then start=1 -> state IDLE (pc_le=0, cu_mux_s=1), then RUN one edge after start; counters=0.
- Load-use: ex_load=1, ex_rd=5, ex_rf_en=1, id_rs1=5, id_use_rs1=1 -> one cycle with pc_le=0, if_id_le=0, cu_mux_s=1, state=STALL, stall_cnt=1. Next cycle with mem_rd=5: fwd_a=10.
- %g0: ex_load=1, ex_rd=0, id_rs1=0 -> no stall, fwd_a=00.
- Forward priority: ex_rd=mem_rd=wb_rd=7, all rf_en=1, id_rs2=7, id_use_rs2=1, no load -> fwd_b=01. Drop ex_rf_en -> 10. Then drop mem_rf_en -> 11.
- Annul: BA with a=1 (id_cond_true=1, id_branch_always=1) -> pc_sel=1, if_id_flush=1, state ANNUL next, annul_cnt=1. BNE with a=1 not taken -> pc_sel=0, if_id_flush=1. BNE with a=1 taken -> pc_sel=1, if_id_flush=0.
- CC hazard plus reset: id_branch=1, ex_cc_en=1 -> STALL, branch suppressed (pc_sel=0). Assert clr during STALL -> IDLE immediately, both counters 0.
